// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its lane formatter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store byte lanes; addr_lo is expected to be already aligned for the access size.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    byte_en = 4'b0001 << addr_lo;
            F3_H:    byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte/halfword placement: load extract with sign/zero extension and store replication.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase

        // Replicating across lanes lets the byte enables alone pick the destination.
        case (funct3[1:0])
            2'b00:   store_word = {4{wdata[7:0]}};
            2'b01:   store_word = {2{wdata[15:0]}};
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: valid/ready request, programmable wait states, one-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int    DEPTH       = 64,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          cur_we;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    addr_lo;
    logic          illegal, misalign, access_err, commit;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   load_data, store_word;
    logic          unused_addr_hi;

    logic [31:0]   mem [DEPTH];

    assign unused_addr_hi = ^req_addr[31:AW+2];

    always_comb begin
        // Live inputs while IDLE so a zero-wait access can commit on its accept edge.
        cur_we    = (state_q == IDLE) ? req_we             : we_q;
        cur_f3    = (state_q == IDLE) ? req_funct3         : f3_q;
        cur_addr  = (state_q == IDLE) ? req_addr[AW+1:0]   : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata          : wdata_q;

        if (cur_we)
            illegal = !(cur_f3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef DMEM_MISALIGN_TRAP_EN
        addr_lo  = cur_addr[1:0];
        misalign = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
        case (cur_f3[1:0])
            2'b01:   addr_lo = {cur_addr[1], 1'b0};
            2'b10:   addr_lo = 2'b00;
            default: addr_lo = cur_addr[1:0];
        endcase
        misalign = 1'b0;
`endif

        access_err = illegal || misalign;
        idx        = cur_addr[AW+1:2];
        be         = (access_err || !cur_we) ? 4'b0000 : byte_en(cur_f3, addr_lo);
        commit     = reset && (((state_q == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                               ((state_q == WAIT) && (cnt_q == 4'd0)));
    end

    dmem_lane_fmt u_lane_fmt (
        .funct3     (cur_f3),
        .addr_lo    (addr_lo),
        .rword      (mem[idx]),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            resp_valid_d = 1'b1;
            err_d        = access_err;
            rdata_d      = (access_err || cur_we) ? 32'h0 : load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the RAM has no reset so it maps onto block memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stall      = req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with one wait state, one with none.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
    logic [2:0]  a_req_funct3 = 3'b0;
    logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0, a_resp_rdata;
    logic        a_resp_valid, a_resp_err, a_stall;

    logic        z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
    logic [2:0]  z_req_funct3 = 3'b0;
    logic [31:0] z_req_addr = 32'h0, z_req_wdata = 32'h0, z_resp_rdata;
    logic        z_resp_valid, z_resp_err, z_stall;

    dmem_ctrl #(.DEPTH(64), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_funct3(a_req_funct3), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .stall(a_stall)
    );

    dmem_ctrl #(.DEPTH(64), .WAIT_STATES(0)) u_dut_z (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(z_req_we), .req_funct3(z_req_funct3), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err), .stall(z_stall)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } op_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] obs_rdata;
    logic        obs_err;
    bit          obs_ok, obs_hs;
    int          obs_lat;

    function automatic op_t mk(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        op_t o;
        o.we = we; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.err = err;
        return o;
    endfunction

    task automatic drive(input bit use_z, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (use_z) begin
            z_req_valid = v; z_req_we = we; z_req_funct3 = f3; z_req_addr = addr; z_req_wdata = wdata;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wdata;
        end
    endtask

    // One request held until its response; records data, stalled cycles and handshake sanity.
    task automatic txn(input bit use_z, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
        int k;
        logic v, st, rdy;
        @(posedge clk); #1;
        drive(use_z, 1'b1, we, f3, addr, wdata);
        obs_ok = 0; obs_hs = 1; obs_lat = 0; k = 0;
        obs_rdata = 'x; obs_err = 'x;
        while (!obs_ok && k < 40) begin
            @(negedge clk);
            v   = use_z ? z_resp_valid : a_resp_valid;
            st  = use_z ? z_stall      : a_stall;
            rdy = use_z ? z_req_ready  : a_req_ready;
            if (v === 1'b1) begin
                obs_ok    = 1;
                obs_rdata = use_z ? z_resp_rdata : a_resp_rdata;
                obs_err   = use_z ? z_resp_err   : a_resp_err;
                if (st !== 1'b0 || rdy !== 1'b0) obs_hs = 0;
            end else begin
                obs_lat++;
                if (st !== 1'b1 || rdy !== (k == 0)) obs_hs = 0;
            end
            k++;
        end
        @(posedge clk); #1;
        drive(use_z, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_resp_valid === 1'b0 && a_resp_rdata === 32'h0 && a_resp_err === 1'b0) n_pass++;
        else $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
                      a_resp_valid, a_resp_rdata, a_resp_err);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_req_ready === 1'b1 && z_req_ready === 1'b1 && a_stall === 1'b0) n_pass++;
        else $display("FAIL reset_ready: got ready_a=%b ready_z=%b stall=%b, want 1/1/0",
                      a_req_ready, z_req_ready, a_stall);
    endtask

    task automatic test_subword();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(1, F3_W,  32'h64, 32'h0000_0019, 32'h0, 0));
        ops.push_back(mk(0, F3_W,  32'h64, 32'h0,         32'h0000_0019, 0));
        ops.push_back(mk(1, F3_B,  32'h65, 32'h1234_5680, 32'h0, 0));
        ops.push_back(mk(0, F3_B,  32'h65, 32'h0,         32'hFFFF_FF80, 0));
        ops.push_back(mk(0, F3_BU, 32'h65, 32'h0,         32'h0000_0080, 0));
        ops.push_back(mk(0, F3_W,  32'h64, 32'h0,         32'h0000_8019, 0));
        ops.push_back(mk(1, F3_H,  32'h66, 32'h5555_BEEF, 32'h0, 0));
        ops.push_back(mk(0, F3_H,  32'h66, 32'h0,         32'hFFFF_BEEF, 0));
        ops.push_back(mk(0, F3_HU, 32'h66, 32'h0,         32'h0000_BEEF, 0));
        ops.push_back(mk(0, F3_W,  32'h64, 32'h0,         32'hBEEF_8019, 0));
        foreach (ops[i]) begin
            sb_q.push_back(exp_t'{ops[i].rdata, ops[i].err});
            txn(1'b0, ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_ok && obs_rdata === e.rdata && obs_err === e.err) n_pass++;
            else $display("FAIL subword[%0d] data: got ok=%b rdata=%h err=%b, want rdata=%h err=%b",
                          i, obs_ok, obs_rdata, obs_err, e.rdata, e.err);
            n_checks++;
            if (obs_ok && obs_lat == 2 && obs_hs) n_pass++;
            else $display("FAIL subword[%0d] timing: got stall_cycles=%0d handshake_ok=%b, want 2/1",
                          i, obs_lat, obs_hs);
        end
    endtask

    task automatic test_drop_valid();
        int k;
        bit got;
        sb_q.push_back(exp_t'{32'h0000_00EF, 1'b0});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, F3_BU, 32'h66, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        got = 0; k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            if (a_resp_valid === 1'b1) got = 1;
            k++;
        end
        begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (got && a_resp_rdata === e.rdata && a_resp_err === e.err) n_pass++;
            else $display("FAIL drop_valid: got resp=%b rdata=%h err=%b, want 1/%h/%b",
                          got, a_resp_rdata, a_resp_err, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   want_resp;
        txn(1'b1, 1'b1, F3_W, 32'h0, 32'h1111_1111);
        n_checks++;
        if (obs_ok && obs_err === 1'b0 && obs_lat == 1 && obs_hs) n_pass++;
        else $display("FAIL b2b_store0: got ok=%b err=%b stall_cycles=%0d hs=%b, want 1/0/1/1",
                      obs_ok, obs_err, obs_lat, obs_hs);
        txn(1'b1, 1'b1, F3_W, 32'h4, 32'h2222_2222);
        sb_q.push_back(exp_t'{32'h1111_1111, 1'b0});
        sb_q.push_back(exp_t'{32'h2222_2222, 1'b0});
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            want_resp = (k % 2 == 1);
            n_checks++;
            if (z_resp_valid === want_resp && z_req_ready === !want_resp && z_stall === !want_resp)
                n_pass++;
            else $display("FAIL b2b_cycle%0d: got resp=%b ready=%b stall=%b, want resp=%b ready=%b stall=%b",
                          k, z_resp_valid, z_req_ready, z_stall, want_resp, !want_resp, !want_resp);
            if (z_resp_valid === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (z_resp_rdata === e.rdata && z_resp_err === e.err) n_pass++;
                else $display("FAIL b2b_data%0d: got rdata=%h err=%b, want rdata=%h err=%b",
                              k, z_resp_rdata, z_resp_err, e.rdata, e.err);
            end
            if (k == 1) begin
                @(posedge clk); #1;
                z_req_addr = 32'h4;
            end
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL b2b_drain: got %0d responses outstanding, want 0", sb_q.size());
        sb_q.delete();
    endtask

    task automatic test_misalign_illegal();
        op_t  ops[$];
        exp_t e;
        ops.push_back(mk(1, F3_W, 32'h60, 32'h1234_5678, 32'h0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        ops.push_back(mk(0, F3_W, 32'h62, 32'h0,         32'h0, 1));
        ops.push_back(mk(1, F3_H, 32'h61, 32'h0000_ABCD, 32'h0, 1));
        ops.push_back(mk(0, F3_W, 32'h60, 32'h0,         32'h1234_5678, 0));
`else
        ops.push_back(mk(0, F3_W, 32'h62, 32'h0,         32'h1234_5678, 0));
        ops.push_back(mk(1, F3_H, 32'h61, 32'h0000_ABCD, 32'h0, 0));
        ops.push_back(mk(0, F3_W, 32'h60, 32'h0,         32'h1234_ABCD, 0));
`endif
        ops.push_back(mk(1, 3'b011, 32'h64, 32'hFFFF_FFFF, 32'h0, 1));
        ops.push_back(mk(0, 3'b110, 32'h64, 32'h0,         32'h0, 1));
        ops.push_back(mk(0, F3_W,   32'h64, 32'h0,         32'hBEEF_8019, 0));
        foreach (ops[i]) begin
            sb_q.push_back(exp_t'{ops[i].rdata, ops[i].err});
            txn(1'b0, ops[i].we, ops[i].f3, ops[i].addr, ops[i].wdata);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_ok && obs_rdata === e.rdata && obs_err === e.err) n_pass++;
            else $display("FAIL align_illegal[%0d]: got ok=%b rdata=%h err=%b, want rdata=%h err=%b",
                          i, obs_ok, obs_rdata, obs_err, e.rdata, e.err);
            if (i == 4) begin
                @(negedge clk);
                n_checks++;
                if (a_resp_err === 1'b0 && a_resp_valid === 1'b0) n_pass++;
                else $display("FAIL err_clear: got err=%b valid=%b, want 0/0", a_resp_err, a_resp_valid);
            end
        end
    endtask

    task automatic test_reset_abort();
        txn(1'b0, 1'b1, F3_W, 32'h8, 32'hCAFE_F00D);
        txn(1'b0, 1'b0, F3_W, 32'h8, 32'h0);
        n_checks++;
        if (obs_ok && obs_rdata === 32'hCAFE_F00D) n_pass++;
        else $display("FAIL abort_setup: got rdata=%h, want cafef00d", obs_rdata);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, F3_W, 32'h8, 32'h0000_DEAD);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_req_ready === 1'b0 && a_resp_valid === 1'b0) n_pass++;
        else $display("FAIL abort_in_wait: got ready=%b valid=%b, want 0/0", a_req_ready, a_resp_valid);
        reset = 1'b0;
        #1;
        n_checks++;
        if (a_resp_valid === 1'b0 && a_resp_rdata === 32'h0 && a_resp_err === 1'b0) n_pass++;
        else $display("FAIL abort_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
                      a_resp_valid, a_resp_rdata, a_resp_err);
        drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_req_ready === 1'b1 && a_resp_valid === 1'b0) n_pass++;
        else $display("FAIL abort_release: got ready=%b valid=%b, want 1/0", a_req_ready, a_resp_valid);
        sb_q.push_back(exp_t'{32'hCAFE_F00D, 1'b0});
        txn(1'b0, 1'b0, F3_W, 32'h8, 32'h0);
        begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_ok && obs_rdata === e.rdata && obs_err === e.err) n_pass++;
            else $display("FAIL abort_ram: got ok=%b rdata=%h err=%b, want rdata=%h err=%b",
                          obs_ok, obs_rdata, obs_err, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_drop_valid();
        test_back_to_back();
        test_misalign_illegal();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
